// File: rtl/block_put_pkg.sv
// block_put_pkg: shared tile/matrix defaults and FSM state encoding for block_put.
package block_put_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int J_DEF      = 2;
    localparam int K_DEF      = 2;
    localparam int ADDR_W_DEF = 10;
    typedef enum logic [1:0] {IDLE, WRITE, DONE, READ} state_t;
endpackage

// File: rtl/block_put_addr_gen.sv
// block_put_addr_gen: row-major slot counters, wide address multiply-add and range check.
module block_put_addr_gen
    import block_put_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int J      = J_DEF,
    parameter int K      = K_DEF,
    localparam int IW    = (J * K > 1) ? $clog2(J * K) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic [ADDR_W-1:0] row,
    input  logic [ADDR_W-1:0] col,
    input  logic [ADDR_W-1:0] num_cols,
    input  logic [ADDR_W-1:0] matrix_len,
    output logic [ADDR_W-1:0] a,
    output logic [IW-1:0]     idx,
    output logic              valid_slot,
    output logic              last_slot
);
    localparam int RW = (J > 1) ? $clog2(J) : 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int WW = 2 * ADDR_W + 2;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [WW-1:0] rr, cc, a_w;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            c <= '0;
        end else if (adv) begin
            c <= (c == CW'(K - 1)) ? '0 : c + 1'b1;
            if (c == CW'(K - 1))
                r <= (r == RW'(J - 1)) ? '0 : r + 1'b1;
        end
    end
    // Wide enough that (row+r)*num_cols+col+c never wraps before the range test.
    always_comb begin
        rr         = WW'(row) + WW'(r);
        cc         = WW'(col) + WW'(c);
        a_w        = rr * WW'(num_cols) + cc;
        valid_slot = (cc < WW'(num_cols)) && (a_w < WW'(matrix_len));
        a          = a_w[ADDR_W-1:0];
        idx        = IW'(int'(r) * K + int'(c));
        last_slot  = (r == RW'(J - 1)) && (c == CW'(K - 1));
    end
endmodule

// File: rtl/block_put.sv
// block_put: writes a J x K tile into a row-major matrix buffer, clipping overhang.
// BLOCK_PUT_ACCUM_EN adds read-modify-write accumulation via mem_re/mem_rdata.
module block_put
    import block_put_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int J      = J_DEF,
    parameter int K      = K_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_row,
    input  logic [ADDR_W-1:0]     start_col,
    input  logic [ADDR_W-1:0]     num_cols,
    input  logic [ADDR_W-1:0]     matrix_len,
    input  logic [J*K*DATA_W-1:0] block,
`ifdef BLOCK_PUT_ACCUM_EN
    output logic                  mem_re,
    input  logic [DATA_W-1:0]     mem_rdata,
`endif
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  busy,
    output logic                  done
);
    localparam int IW = (J * K > 1) ? $clog2(J * K) : 1;
    state_t state, state_n;
    logic [ADDR_W-1:0]     row_q, col_q, nc_q, len_q, addr_n;
    logic [J*K*DATA_W-1:0] blk_q, blk_src;
    logic [ADDR_W-1:0]     a;
    logic [IW-1:0]         idx;
    logic [DATA_W-1:0]     elem;
    logic idle, load, valid_slot, last_slot, last_q, last_n, we_n, busy_n, done_n;
    // While idle the origin comes straight from the inputs so slot 0 lands on the start edge.
    assign idle    = (state == IDLE);
    assign load    = (idle && start) || (state == WRITE && !last_q);
    assign blk_src = idle ? block : blk_q;
    assign elem    = blk_src[int'(idx)*DATA_W +: DATA_W];
    block_put_addr_gen #(.ADDR_W(ADDR_W), .J(J), .K(K)) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .adv        (load),
        .row        (idle ? start_row : row_q),
        .col        (idle ? start_col : col_q),
        .num_cols   (idle ? num_cols : nc_q),
        .matrix_len (idle ? matrix_len : len_q),
        .a          (a),
        .idx        (idx),
        .valid_slot (valid_slot),
        .last_slot  (last_slot)
    );
`ifdef BLOCK_PUT_ACCUM_EN
    logic [DATA_W-1:0] elem_q, elem_n;
    logic              val_q, val_n, re_n;
    // Read data arrives in the write cycle, so the sum is formed on the way out.
    assign mem_wdata = mem_we ? DATA_W'(mem_rdata + elem_q) : '0;
`else
    logic [DATA_W-1:0] wdata_n;
`endif
    always_comb begin
        state_n = state;
        busy_n  = busy;
        done_n  = 1'b0;
        we_n    = 1'b0;
        addr_n  = mem_addr;
        last_n  = last_q;
`ifdef BLOCK_PUT_ACCUM_EN
        re_n    = 1'b0;
        elem_n  = elem_q;
        val_n   = val_q;
`else
        wdata_n = mem_wdata;
`endif
        if (load) begin
            last_n = last_slot;
            addr_n = a;
            busy_n = 1'b1;
`ifdef BLOCK_PUT_ACCUM_EN
            re_n    = valid_slot;
            val_n   = valid_slot;
            elem_n  = elem;
            state_n = READ;
        end else if (state == READ) begin
            we_n    = val_q;
            state_n = WRITE;
`else
            we_n    = valid_slot;
            wdata_n = elem;
            state_n = WRITE;
`endif
        end else if (state == WRITE) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            last_q   <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            nc_q     <= '0;
            len_q    <= '0;
            blk_q    <= '0;
`ifdef BLOCK_PUT_ACCUM_EN
            mem_re   <= 1'b0;
            elem_q   <= '0;
            val_q    <= 1'b0;
`else
            mem_wdata <= '0;
`endif
        end else begin
            state    <= state_n;
            mem_we   <= we_n;
            mem_addr <= addr_n;
            busy     <= busy_n;
            done     <= done_n;
            last_q   <= last_n;
`ifdef BLOCK_PUT_ACCUM_EN
            mem_re   <= re_n;
            elem_q   <= elem_n;
            val_q    <= val_n;
`else
            mem_wdata <= wdata_n;
`endif
            if (idle && start) begin
                row_q <= start_row;
                col_q <= start_col;
                nc_q  <= num_cols;
                len_q <= matrix_len;
                blk_q <= block;
            end
        end
    end
endmodule

// File: tb/tb_block_put.sv
// tb_block_put: scoreboard bench for block_put; expected writes queued at start, popped on mem_we.
module tb_block_put;
    localparam int DW = 16;
    localparam int AW = 10;
`ifdef BLOCK_PUT_ACCUM_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 5;
`endif
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [AW-1:0] start_row = '0, start_col = '0, num_cols = '0, matrix_len = '0;
    logic [4*DW-1:0] block = '0;
    logic mem_we, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem [0:1023];
    wr_t sb[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

`ifdef BLOCK_PUT_ACCUM_EN
    logic mem_re;
    logic [DW-1:0] mem_rdata = '0;
    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];
`endif
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    block_put dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_row  (start_row),
        .start_col  (start_col),
        .num_cols   (num_cols),
        .matrix_len (matrix_len),
        .block      (block),
`ifdef BLOCK_PUT_ACCUM_EN
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
`endif
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One tile: queue expected writes, start, then check every cycle until one past done.
    task automatic run(input int row, input int col, input int nc, input int len,
                       input logic [4*DW-1:0] blk, input int extra_cyc, input logic [4*DW-1:0] blk2);
        wr_t e;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                longint cc = col + c;
                longint a = longint'(row + r) * nc + cc;
                if (cc < nc && a < len) begin
                    e.a = AW'(a);
`ifdef BLOCK_PUT_ACCUM_EN
                    e.d = mem[AW'(a)] + blk[(r*2+c)*DW +: DW];
`else
                    e.d = blk[(r*2+c)*DW +: DW];
`endif
                    sb.push_back(e);
                end
            end
        @(negedge clk);
        start = 1'b1; start_row = AW'(row); start_col = AW'(col);
        num_cols = AW'(nc); matrix_len = AW'(len); block = blk;
        @(negedge clk);
        start = 1'b0; block = ~blk; start_row = AW'(row + 1); num_cols = AW'(nc + 1);
        for (int cyc = 1; cyc <= LAT; cyc++) begin
            check($sformatf("busy@%0d", cyc), 32'(busy), 32'(cyc < LAT));
            check($sformatf("done@%0d", cyc), 32'(done), 32'(cyc == LAT));
            if (mem_we) begin
                if (sb.size() == 0) check("extra_write", 32'(mem_addr), 32'hFFFFFFFF);
                else begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.a));
                    check("wr_data", 32'(mem_wdata), 32'(e.d));
                end
            end
            start = (cyc == extra_cyc);
            if (cyc == extra_cyc) block = blk2;
            @(negedge clk);
        end
        start = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_we", 32'(mem_we), 32'd0);
        check("missing_writes", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    localparam logic [4*DW-1:0] B1 = {16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [4*DW-1:0] B2 = {16'd40, 16'd30, 16'd20, 16'd10};

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'hDEAD;
        @(negedge clk);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef BLOCK_PUT_ACCUM_EN
        check("rst_re", 32'(mem_re), 32'd0);
`endif
        rst = 1'b0;
        run(0, 0, 4, 16, B1, 0, B1);
        run(2, 3, 4, 12, B1, 0, B1);
        run(0, 0, 4, 16, B2, 2, B1);
        run(1, 1, 4, 16, B1, LAT, B2);
        run(0, 0, 0, 16, B1, 0, B1);
        run(0, 0, 4, 0, B1, 0, B1);
        run(2, 1, 3, 10, B2, 0, B1);
        for (int t = 0; t < 4; t++)
            run($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(1, 8),
                $urandom_range(0, 48), {$urandom, $urandom}, 0, B1);
        // Abort mid-tile: only what was already written stays in memory.
        for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;
        @(negedge clk);
        start = 1'b1; start_row = '0; start_col = '0; num_cols = 4; matrix_len = 16; block = B1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`ifdef BLOCK_PUT_ACCUM_EN
        check("abort_mem0", 32'(mem[0]), 32'hDEAD);
`else
        check("abort_mem0", 32'(mem[0]), 32'd1);
`endif
        check("abort_mem1", 32'(mem[1]), 32'hDEAD);
        run(0, 0, 4, 16, B2, 0, B1);
`ifdef BLOCK_PUT_ACCUM_EN
        mem[0] = 16'd10; mem[1] = 16'd10; mem[4] = 16'd10; mem[5] = 16'd10;
        run(0, 0, 4, 16, B1, 0, B1);
        check("acc_mem0", 32'(mem[0]), 32'd11);
        check("acc_mem1", 32'(mem[1]), 32'd12);
        check("acc_mem4", 32'(mem[4]), 32'd13);
        check("acc_mem5", 32'(mem[5]), 32'd14);
        mem[0] = 16'hFFFF;
        run(0, 0, 4, 16, {16'd0, 16'd0, 16'd0, 16'd2}, 0, B1);
        check("acc_wrap", 32'(mem[0]), 32'h0001);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
